fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 56 +++++
 tb/tb_fetch_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, redirect, imem and IF/ID bundle of the fetch stage
interface fetch_stage_if #(
   parameter int CNT_W = 32
);
   logic             pc_enable;
   logic             IF_ID_enable;
   logic             IF_ID_flush;
   logic             is_taken;
   logic [31:0]      target_E;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_rdata;
   logic [31:0]      pc_F;
   logic [31:0]      instr_D;
   logic [31:0]      pc_D;
   logic [31:0]      pc4_D;
   logic             valid_D;
   logic             misalign_err;
   logic [1:0]       fetch_state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   modport slave (
      input  pc_enable, IF_ID_enable, IF_ID_flush, is_taken, target_E, imem_rdata,
      output imem_addr, pc_F, instr_D, pc_D, pc4_D, valid_D, misalign_err,
             fetch_state, stall_cnt, flush_cnt
   );
   modport master (
      output pc_enable, IF_ID_enable, IF_ID_flush, is_taken, target_E, imem_rdata,
      input  imem_addr, pc_F, instr_D, pc_D, pc4_D, valid_D, misalign_err,
             fetch_state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory address, IF/ID register and stall/flush counters
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 32
) (
   input logic          clk,
   input logic          rst_n,
   fetch_stage_if.slave bus
);
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, REDIR = 2'd3} state_t;
   state_t      state, state_nx;
   logic [31:0] pc_nx;
   logic        redir;
   assign redir           = bus.pc_enable & bus.is_taken;
   assign bus.imem_addr   = bus.pc_F;
   assign bus.fetch_state = state;
   // next state and next PC; a redirect without pc_enable is ignored
   always_comb begin
      state_nx = state == BOOT ? RUN : redir ? REDIR : !bus.pc_enable ? STALL : RUN;
      pc_nx    = !bus.pc_enable ? bus.pc_F : redir ? {bus.target_E[31:2], 2'b00} : bus.pc_F + 32'd4;
   end
   // state, PC, IF/ID and counters; BOOT holds everything for its single cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= BOOT;
         bus.pc_F         <= RESET_PC;
         bus.instr_D      <= NOP_INSTR;
         bus.pc_D         <= '0;
         bus.pc4_D        <= '0;
         bus.valid_D      <= 1'b0;
         bus.misalign_err <= 1'b0;
         bus.stall_cnt    <= '0;
         bus.flush_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (state != BOOT) begin
            bus.pc_F <= pc_nx;
            if (redir && bus.target_E[1:0] != 2'b00) bus.misalign_err <= 1'b1;
            if (bus.IF_ID_flush) begin
               bus.instr_D <= NOP_INSTR;
               bus.pc_D    <= '0;
               bus.pc4_D   <= '0;
               bus.valid_D <= 1'b0;
            end else if (bus.IF_ID_enable) begin
               bus.instr_D <= bus.imem_rdata;
               bus.pc_D    <= bus.pc_F;
               bus.pc4_D   <= bus.pc_F + 32'd4;
               bus.valid_D <= 1'b1;
            end
            if (!bus.pc_enable && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
            if (bus.IF_ID_flush && bus.flush_cnt != '1) bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   fetch_stage_if #(.CNT_W(32)) bus ();
   fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   // instruction memory returns a pattern derived from the address
   always_comb bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic pe, input logic ie, input logic fl, input logic tk, input logic [31:0] tg);
      bus.pc_enable    = pe;
      bus.IF_ID_enable = ie;
      bus.IF_ID_flush  = fl;
      bus.is_taken     = tk;
      bus.target_E     = tg;
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, bus.pc_F, 32'h0);
      chk({tag, "_instr"}, bus.instr_D, 32'h13);
      chk({tag, "_pcD"}, bus.pc_D, 32'h0);
      chk({tag, "_pc4D"}, bus.pc4_D, 32'h0);
      chk({tag, "_valid"}, 32'(bus.valid_D), 32'h0);
      chk({tag, "_mis"}, 32'(bus.misalign_err), 32'h0);
      chk({tag, "_state"}, 32'(bus.fetch_state), 32'h0);
      chk({tag, "_stall"}, bus.stall_cnt, 32'h0);
      chk({tag, "_flush"}, bus.flush_cnt, 32'h0);
   endtask
   initial begin
      rst_n = 1'b0;
      drive(1, 1, 0, 0, 32'h0);
      step();
      chk_reset("rst");
      rst_n = 1'b1;
      step();
      chk("boot_state", 32'(bus.fetch_state), 32'h1);
      chk("boot_pc", bus.pc_F, 32'h0);
      chk("boot_valid", 32'(bus.valid_D), 32'h0);
      step();
      chk("run_pc4", bus.pc_F, 32'h4);
      chk("run_instr0", bus.instr_D, 32'hA5A5_0000);
      step();
      chk("run_pc8", bus.pc_F, 32'h8);
      chk("run_instr4", bus.instr_D, 32'hA5A5_0004);
      chk("run_valid", 32'(bus.valid_D), 32'h1);
      chk("run_pcD", bus.pc_D, 32'h4);
      chk("run_pc4D", bus.pc4_D, 32'h8);
      step();
      step();
      chk("pre_stall_pc", bus.pc_F, 32'h10);
      drive(0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", bus.pc_F, 32'h10);
         chk("stall_instr", bus.instr_D, 32'hA5A5_000C);
         chk("stall_state", 32'(bus.fetch_state), 32'h2);
      end
      chk("stall_cnt3", bus.stall_cnt, 32'h3);
      drive(1, 1, 0, 0, 32'h0);
      step();
      chk("resume_pc", bus.pc_F, 32'h14);
      chk("resume_instr", bus.instr_D, 32'hA5A5_0010);
      chk("resume_state", 32'(bus.fetch_state), 32'h1);
      repeat (11) step();
      chk("pc_40", bus.pc_F, 32'h40);
      drive(1, 1, 1, 1, 32'h200);
      step();
      chk("redir_pc", bus.pc_F, 32'h200);
      chk("redir_instr", bus.instr_D, 32'h13);
      chk("redir_valid", 32'(bus.valid_D), 32'h0);
      chk("redir_state", 32'(bus.fetch_state), 32'h3);
      chk("redir_flush", bus.flush_cnt, 32'h1);
      drive(1, 1, 0, 0, 32'h0);
      step();
      chk("redir_pcD", bus.pc_D, 32'h200);
      chk("redir_instrD", bus.instr_D, 32'hA5A5_0200);
      chk("redir_pcF", bus.pc_F, 32'h204);
      drive(1, 1, 0, 1, 32'h102);
      step();
      chk("mis_pc", bus.pc_F, 32'h100);
      chk("mis_err", 32'(bus.misalign_err), 32'h1);
      drive(1, 1, 0, 0, 32'h0);
      repeat (3) step();
      chk("mis_sticky", 32'(bus.misalign_err), 32'h1);
      chk("mis_pc_after", bus.pc_F, 32'h10C);
      drive(0, 0, 1, 0, 32'h0);
      step();
      chk("both_instr", bus.instr_D, 32'h13);
      chk("both_valid", 32'(bus.valid_D), 32'h0);
      chk("both_pcD", bus.pc_D, 32'h0);
      chk("both_pc", bus.pc_F, 32'h10C);
      chk("both_stall", bus.stall_cnt, 32'h4);
      chk("both_flush", bus.flush_cnt, 32'h2);
      drive(1, 1, 0, 0, 32'h0);
      step();
      chk("both_resume_pc", bus.pc_F, 32'h110);
      chk("both_resume_instr", bus.instr_D, 32'hA5A5_010C);
      drive(1, 1, 0, 1, 32'hFFFF_FFFC);
      step();
      chk("wrap_pre", bus.pc_F, 32'hFFFF_FFFC);
      drive(1, 1, 0, 0, 32'h0);
      step();
      chk("wrap_pc", bus.pc_F, 32'h0);
      chk("wrap_pc4D", bus.pc4_D, 32'h0);
      chk("wrap_pcD", bus.pc_D, 32'hFFFF_FFFC);
      chk("wrap_instr", bus.instr_D, 32'h5A5A_FFFC);
      drive(0, 1, 0, 0, 32'h0);
      step();
      chk("pre_rst_state", 32'(bus.fetch_state), 32'h2);
      rst_n = 1'b0;
      drive(1, 1, 1, 1, 32'h300);
      step();
      chk_reset("midrst");
      rst_n = 1'b1;
      drive(1, 1, 1, 1, 32'h300);
      step();
      chk("boot2_pc", bus.pc_F, 32'h0);
      chk("boot2_instr", bus.instr_D, 32'h13);
      chk("boot2_flush", bus.flush_cnt, 32'h0);
      chk("boot2_mis", 32'(bus.misalign_err), 32'h0);
      chk("boot2_state", 32'(bus.fetch_state), 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
